// File: rtl/id_link_master.sv
// id_link_master
//   Host-side word-serial driver for the instruction-decode verification
//   wrapper. One transaction latches a decode test vector (instruction,
//   write-back data, write-back register, write enable). It then:
//     1. shifts instr, wdata and the zero-extended wreg into the wrapper's
//        SIPO (3 cycles, o_enable_sipo=1);
//     2. holds o_RegWrite for SETTLE_CYCLES cycles while the wreg word stays
//        on the bus;
//     3. runs 4 capture cycles: the PISO enable is high for the first 3, and
//        the wrapper's outputs (one cycle behind the enable) are registered
//        into o_register1, o_register2 and o_constante;
//     4. pulses o_done for one cycle and returns to IDLE.
//   All outputs are registered.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_start               transaction request, sampled only in IDLE
//   i_instr, i_wdata      instruction / write-back data words
//   i_wreg, i_regwrite    write-back register address / write enable
//   o_parallel_out        word bus to the wrapper's parallel input
//   o_enable_sipo/piso    wrapper shift/load enables
//   o_RegWrite            wrapper RegWrite pin
//   i_parallel_in         word bus from the wrapper's parallel output
//   o_register1/2,
//   o_constante           captured decode results
//   o_busy, o_done        status: in progress / one-cycle completion pulse
module id_link_master #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned REGADDR_W     = 5,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_instr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [REGADDR_W-1:0] i_wreg,
  input  logic                 i_regwrite,
  output logic [WIDTH-1:0]     o_parallel_out,
  output logic                 o_enable_sipo,
  output logic                 o_enable_piso,
  output logic                 o_RegWrite,
  input  logic [WIDTH-1:0]     i_parallel_in,
  output logic [WIDTH-1:0]     o_register1,
  output logic [WIDTH-1:0]     o_register2,
  output logic [WIDTH-1:0]     o_constante,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > 4) ? SETTLE_CYCLES : 4;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  // Count value of the last settle cycle; unreachable when SETTLE_CYCLES=0.
  localparam logic [CW-1:0] SETTLE_LAST =
    CW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [WIDTH-1:0]       instr_q;
  logic [WIDTH-1:0]       wdata_q;
  logic [REGADDR_W-1:0]   wreg_q;
  logic                   regwrite_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= ST_IDLE;
      count          <= '0;
      instr_q        <= '0;
      wdata_q        <= '0;
      wreg_q         <= '0;
      regwrite_q     <= 1'b0;
      o_parallel_out <= '0;
      o_enable_sipo  <= 1'b0;
      o_enable_piso  <= 1'b0;
      o_RegWrite     <= 1'b0;
      o_register1    <= '0;
      o_register2    <= '0;
      o_constante    <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            instr_q        <= i_instr;
            wdata_q        <= i_wdata;
            wreg_q         <= i_wreg;
            regwrite_q     <= i_regwrite;
            // First SEND word goes out straight from the inputs so the bus
            // is valid in the very first SEND cycle.
            o_parallel_out <= i_instr;
            o_enable_sipo  <= 1'b1;
            o_busy         <= 1'b1;
            count          <= '0;
            state          <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (count == CW'(2)) begin
            count         <= '0;
            o_enable_sipo <= 1'b0;
            if (SETTLE_CYCLES == 0) begin
              o_parallel_out <= '0;
              o_enable_piso  <= 1'b1;
              state          <= ST_CAPTURE;
            end else begin
              o_RegWrite <= regwrite_q;
              state      <= ST_SETTLE;
            end
          end else begin
            count          <= count + 1'b1;
            o_parallel_out <= (count == '0) ? wdata_q : WIDTH'(wreg_q);
          end
        end

        ST_SETTLE: begin
          if (count == SETTLE_LAST) begin
            count          <= '0;
            o_RegWrite     <= 1'b0;
            o_parallel_out <= '0;
            o_enable_piso  <= 1'b1;
            state          <= ST_CAPTURE;
          end else begin
            count <= count + 1'b1;
          end
        end

        ST_CAPTURE: begin
          count <= count + 1'b1;
          // Wrapper output lags its enable by one cycle, so results land in
          // capture cycles 2..4 (count 1..3).
          case (count)
            CW'(1): o_register1 <= i_parallel_in;
            CW'(2): begin
              o_register2   <= i_parallel_in;
              o_enable_piso <= 1'b0;
            end
            CW'(3): begin
              o_constante <= i_parallel_in;
              count       <= '0;
              o_busy      <= 1'b0;
              o_done      <= 1'b1;
              state       <= ST_DONE;
            end
            default: ;
          endcase
        end

        ST_DONE: begin
          o_done <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          count <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_link_master.sv
// Bench for id_link_master: two instances (settle window 2 and 0) share one
// stimulus stream. Each lane has a timeline reference model, a wrapper model
// answering PISO enables with pre-drawn words, a per-cycle output checker and
// a result scoreboard checked on o_done.
module tb_id_link_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] instr, wdata;
  logic [4:0]  wreg;
  logic        regwrite;
  logic [31:0] next_resp [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int S = (g == 0) ? 2 : 0;

    logic [31:0] par_out, par_in, r1, r2, cst;
    logic        sipo, piso, rwo, busy, done;

    id_link_master #(
      .WIDTH(32),
      .REGADDR_W(5),
      .SETTLE_CYCLES(S)
    ) dut (
      .i_clk(clk),
      .i_reset(rst_n),
      .i_start(start),
      .i_instr(instr),
      .i_wdata(wdata),
      .i_wreg(wreg),
      .i_regwrite(regwrite),
      .o_parallel_out(par_out),
      .o_enable_sipo(sipo),
      .o_enable_piso(piso),
      .o_RegWrite(rwo),
      .i_parallel_in(par_in),
      .o_register1(r1),
      .o_register2(r2),
      .o_constante(cst),
      .o_busy(busy),
      .o_done(done)
    );

    // Reference model: k is the cycle number within the transaction.
    bit          active = 1'b0;
    int          k = 0;
    int          pend = 0;
    logic [31:0] m_instr, m_wdata;
    logic [4:0]  m_wreg;
    logic        m_rw;
    logic [31:0] m_resp [3];
    logic [31:0] m_res  [3];
    logic [31:0] wq [$];
    logic [95:0] expq [$];

    initial begin
      m_res = '{32'h0, 32'h0, 32'h0};
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          active = 1'b0;
          k = 0;
          m_res = '{32'h0, 32'h0, 32'h0};
          wq.delete();
          expq.delete();
        end else if (active) begin
          if (k == 5 + S) m_res[0] = m_resp[0];
          if (k == 6 + S) m_res[1] = m_resp[1];
          if (k == 7 + S) m_res[2] = m_resp[2];
          if (k == 8 + S) active = 1'b0;
          else k++;
        end else if (start) begin
          active  = 1'b1;
          k       = 1;
          m_instr = instr;
          m_wdata = wdata;
          m_wreg  = wreg;
          m_rw    = regwrite;
          m_resp  = next_resp;
          for (int i = 0; i < 3; i++) wq.push_back(next_resp[i]);
          expq.push_back({next_resp[0], next_resp[1], next_resp[2]});
        end
        pend = expq.size();
      end
    end

    // Wrapper model: the word appears on its output one cycle after an enable.
    initial begin
      bit p;
      par_in = 32'h0;
      forever begin
        @(negedge clk);
        p = piso;
        @(posedge clk);
        #2;
        if (p && wq.size() > 0) par_in = wq.pop_front();
        else                    par_in = $urandom();
      end
    end

    // Per-cycle output check against the model timeline.
    initial begin
      logic [132:0] e, a;
      logic [31:0]  eb;
      forever begin
        @(negedge clk);
        eb = 32'h0;
        if (active) begin
          if (k == 1)                 eb = m_instr;
          else if (k == 2)            eb = m_wdata;
          else if (k >= 3 && k <= 3 + S) eb = {27'h0, m_wreg};
        end
        e = {active && k >= 1 && k <= 3,
             active && k >= 4 + S && k <= 6 + S,
             active && m_rw && k >= 4 && k <= 3 + S,
             active && k <= 7 + S,
             active && k == 8 + S,
             eb, m_res[0], m_res[1], m_res[2]};
        a = {sipo, piso, rwo, busy, done, par_out, r1, r2, cst};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL lane%0d outputs t=%0t k=%0d got=%h expected=%h",
                   g, $time, k, a, e);
        end
      end
    end

    // Scoreboard: each completion must return the words drawn at its start.
    initial begin
      logic [95:0] ex;
      forever begin
        @(negedge clk);
        if (done === 1'b1) begin
          tests++;
          if (expq.size() == 0) begin
            fails++;
            $display("FAIL lane%0d unexpected_done t=%0t got=done expected=none",
                     g, $time);
          end else begin
            ex = expq.pop_front();
            pend = expq.size();
            if ({r1, r2, cst} !== ex) begin
              fails++;
              $display("FAIL lane%0d results t=%0t got=%h expected=%h",
                       g, $time, {r1, r2, cst}, ex);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    instr    = $urandom();
    wdata    = $urandom();
    wreg     = 5'($urandom_range(0, 31));
    regwrite = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) next_resp[i] = $urandom();
  endtask

  task automatic one_txn();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    instr    = 32'h0;
    wdata    = 32'h0;
    wreg     = 5'h0;
    regwrite = 1'b0;
    next_resp = '{32'h0, 32'h0, 32'h0};

    // Reset, then release with no start.
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Nominal vector with fixed wrapper answers.
    instr    = 32'h00A30293;
    wdata    = 32'hDEADBEEF;
    wreg     = 5'd5;
    regwrite = 1'b1;
    next_resp = '{32'h11111111, 32'h22222222, 32'h33333333};
    one_txn();
    repeat (12) step();

    // Next transaction: results must hold through its SEND.
    rand_vec();
    one_txn();
    repeat (12) step();

    // Starts sampled at cycles 2, 6 and 10 of an active transaction.
    rand_vec();
    one_txn();
    for (int c = 2; c <= 12; c++) begin
      start = (c == 2 || c == 6 || c == 10);
      step();
    end
    start = 1'b0;
    repeat (12) step();

    // Reset asserted in cycle 5, then a full transaction.
    rand_vec();
    one_txn();
    repeat (3) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    rand_vec();
    one_txn();
    repeat (12) step();

    // Random traffic with rare resets.
    for (int i = 0; i < 1500; i++) begin
      rand_vec();
      start = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    start = 1'b0;
    rst_n = 1'b1;

    // Drain, bounded.
    for (int i = 0; i < 40 && (lane[0].active || lane[1].active); i++) step();
    if (lane[0].active || lane[1].active) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got=busy expected=idle");
    end
    step();
    tests++;
    if (lane[0].pend != 0) begin
      fails++;
      $display("FAIL lane0 pending got=%0d expected=0", lane[0].pend);
    end
    tests++;
    if (lane[1].pend != 0) begin
      fails++;
      $display("FAIL lane1 pending got=%0d expected=0", lane[1].pend);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_link_master.md
# id_link_master

Word-serial host-side driver for the instruction-decode verification wrapper. It latches one decode test vector: instruction, write-back data, write-back register and write enable. It shifts the vector into the wrapper's SIPO over a single WIDTH-bit bus, holds the write enable for a programmable settle window, then clocks the wrapper's PISO and collects the three decode results: register1, register2 and constante. It sits between a stimulus source (bench sequencer or on-chip self-test) and the wrapper's parallel bus, enable and RegWrite pins.

## Interface
- WIDTH, 32, data/bus word width
- REGADDR_W, 5, register-address width; must be ≤ WIDTH
- SETTLE_CYCLES, 2, cycles between the last SIPO word and the first PISO enable; 0 is legal
- i_clk  in  1  single clock; all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  request a transaction; sampled only in IDLE
- i_instr  in  WIDTH  instruction word
- i_wdata  in  WIDTH  write-back data
- i_wreg  in  REGADDR_W  write-back register address
- i_regwrite  in  1  write enable to present during settle
- o_parallel_out  out  WIDTH  word bus to the wrapper's parallel input
- o_enable_sipo  out  1  SIPO shift enable
- o_enable_piso  out  1  PISO load/shift enable
- o_RegWrite  out  1  drives the wrapper's RegWrite pin
- i_parallel_in  in  WIDTH  word bus from the wrapper's parallel output
- o_register1, o_register2, o_constante  out  WIDTH each  captured results
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SEND, SETTLE, CAPTURE, DONE. A single counter is shared across states, sized for max(4, SETTLE_CYCLES).
- IDLE:
  - i_start=1 latches i_instr, i_wdata, i_wreg and i_regwrite, then moves to SEND with count=0.
  - i_start while not in IDLE is ignored. Inputs are not re-sampled mid-transaction.
- SEND: lasts 3 cycles with o_enable_sipo=1.
  - o_parallel_out = instr, then wdata, then wreg zero-extended to WIDTH.
  - Next state is SETTLE, or CAPTURE if SETTLE_CYCLES=0.
- SETTLE: lasts SETTLE_CYCLES cycles.
  - o_RegWrite = latched regwrite.
  - o_parallel_out holds the wreg word.
  - Both enables are 0.
- CAPTURE: lasts 4 cycles.
  - o_enable_piso=1 in the first 3 cycles and 0 in the 4th.
  - At the end of capture cycles 2, 3 and 4, i_parallel_in is registered into o_register1, o_register2 and o_constante respectively. The wrapper's PISO output is one cycle behind its enable.
- DONE: lasts 1 cycle.
  - o_done=1, o_busy=0.
  - Returns to IDLE. A start sampled in this cycle is ignored.
- Fixed output values by state:
  - o_RegWrite is 0 outside SETTLE.
  - o_parallel_out is 0 in IDLE, CAPTURE and DONE.
  - o_busy=1 in SEND, SETTLE and CAPTURE only.
- Result registers hold their values until overwritten by the next transaction's capture. Each register updates only in its own capture cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Cycle 0 is the clock edge at which i_start=1 is sampled in IDLE; S = SETTLE_CYCLES.
- Cycles 1–3: SEND. o_enable_sipo=1 and o_busy=1.
- Cycles 4..3+S: SETTLE.
- Cycles 4+S..6+S: o_enable_piso=1.
- Result capture edges: o_register1 at the end of cycle 5+S, o_register2 at 6+S, o_constante at 7+S.
- Cycle 8+S: o_done=1. Back-to-back throughput is one transaction per 9+S cycles.
- Reset, including mid-transaction:
  - Forces IDLE immediately.
  - Clears every output, counter and latched vector: enables, o_RegWrite, o_busy and o_done are 0; o_parallel_out and all three result registers are 0.
  - No partial SIPO/PISO sequence resumes after reset release.
- The counter wraps cleanly at each state exit; it never holds a stale value into the next state.

## Test plan
- Reset check: assert i_reset=0 for 3 cycles -> all outputs 0, o_busy=0; release with i_start=0 -> outputs stay 0.
- Nominal load, S=2: start with instr=0x00A30293, wdata=0xDEADBEEF, wreg=5, regwrite=1 ->
  - cycles 1–3: bus = 0x00A30293, 0xDEADBEEF, 0x00000005 with o_enable_sipo=1;
  - cycles 4–5: o_RegWrite=1;
  - o_done in cycle 10.
- Capture ordering: bench model drives i_parallel_in = 0x11111111, 0x22222222, 0x33333333 one cycle after each piso enable -> o_register1, o_register2 and o_constante equal those values; the registers are unchanged during the next transaction's SEND.
- Start ignored: pulse i_start in cycles 2, 6 and 10 of an active transaction -> exactly one o_done; a new transaction begins only from a start sampled in IDLE after the DONE cycle.
- Mid-operation reset: assert reset in cycle 5 -> o_RegWrite, o_busy and results are cleared at once; no o_done follows; a subsequent start runs a full, correct sequence.
- SETTLE_CYCLES=0 build: o_enable_piso rises in cycle 4; o_RegWrite never asserts; o_done in cycle 8.
